fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side consumer for the codebase's show-ahead FIFO read port (RDENA/RDDAT/RDLEV). It waits until the FIFO holds at least THRESH words, then pops exactly BURST words.
- Popped words are presented on a VLD/RDY stream through a 2-entry skid buffer, with LAST marking the final word of each burst.
- Used to pull fixed-length pixel-line bursts out of the FIFO toward the HDMI output path.

Parameters:
DWID, 32, data word width (matches FIFO DWID)
AWID, 10, FIFO level width (matches FIFO AWID)
BURST, 64, words popped per burst; legal range 1..2**AWID-1
THRESH, 64, minimum FF_RDLEV required to start a burst; legal range 1..2**AWID-1

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-low reset
EN  in  1  permits new bursts to start; sampled only in IDLE
FF_RDENA  out  1  FIFO pop strobe; combinational
FF_RDDAT  in  DWID  FIFO head word; show-ahead, valid when FF_RDLEV!=0
FF_RDLEV  in  AWID  FIFO fill level
DO_VLD  out  1  output word valid
DO_DAT  out  DWID  output word
DO_LAST  out  1  DO_DAT is the last word of the burst; qualified by DO_VLD
DO_RDY  in  1  downstream accept
BUSY  out  1  state != IDLE
UNDERRUN  out  1  one-cycle flag per starved cycle

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, rem=0, occ=0, DO_VLD=0, DO_DAT=0, DO_LAST=0, BUSY=0, UNDERRUN=0, FF_RDENA=0.
- Reset mid-burst aborts immediately. Words already popped but not yet accepted are discarded; no partial LAST is emitted.
- Registers:
  - rem: remaining pops, width $clog2(BURST+1).
  - occ: skid occupancy, 0..2.
  - Two entries of {LAST, DAT}; the head entry drives DO_DAT/DO_LAST.
- State machine:
  - IDLE: if EN=1 and FF_RDLEV>=THRESH (unsigned compare), load rem=BURST and go to BURST next cycle. No pop in the same cycle as the transition.
  - BURST: pop = (FF_RDLEV!=0) && (occ<2) && (rem!=0). FF_RDENA=pop. On a pop edge, FF_RDDAT is written into the buffer tagged LAST=(rem==1), and rem decrements. When rem becomes 0, go to DRAIN.
  - DRAIN: no pops. When occ==0 (the LAST word has been accepted), go to IDLE.
- EN deassertion mid-burst has no effect; the burst always completes all BURST words.
- Latency: a word popped at edge N appears with DO_VLD=1 after edge N (visible in cycle N+1).
- First DO_VLD appears 2 cycles after the IDLE->BURST decision cycle.
- Throughput: one word per cycle while DO_RDY=1 and the FIFO is non-empty. With occ==1 and continuous accepts, pop and accept happen every cycle.
- Buffer update per edge: occ_next = occ + pop - (DO_VLD && DO_RDY). Simultaneous pop and accept at occ==1 keeps occ at 1 and shifts the new word to the head.
- DO_VLD = (occ!=0). DO_DAT and DO_LAST hold stable while DO_VLD=1 and DO_RDY=0.
- Backpressure: at occ==2, pops stop; FIFO words stay in the FIFO. No word is ever dropped or duplicated.
- UNDERRUN=1 (registered, one cycle) for each cycle in BURST with rem!=0, occ<2 and FF_RDLEV==0. This can only happen if THRESH<BURST. The burst then resumes when the FIFO refills.
- DO_LAST is 1 on exactly one accepted word per burst: word number BURST.
- Back-to-back bursts: the earliest next IDLE->BURST decision is the cycle after the DRAIN->IDLE transition.

Test Plan:
- BURST=4, THRESH=4. Preload FIFO with 0x10..0x13, EN=1, DO_RDY=1 -> FF_RDENA high for 4 consecutive cycles. DO_DAT=0x10,0x11,0x12,0x13 on consecutive cycles, DO_LAST=1 only on 0x13, BUSY returns to 0.
- FIFO level 3 < THRESH=4 with EN=1 -> no FF_RDENA and BUSY=0. Write one more word -> burst starts, first DO_VLD 2 cycles after the level reaches 4.
- Mid-burst, hold DO_RDY=0 for 5 cycles -> occ saturates at 2, FF_RDENA=0 and DO_DAT stable. After release, the remaining words arrive in order with no loss or duplicate; total accepted=4.
- THRESH=1, BURST=4, single word in FIFO -> UNDERRUN pulses each starved cycle. Supply 3 more words -> burst completes with DO_LAST on the 4th word.
- Assert RST=0 asynchronously after 2 pops -> all outputs go to 0 immediately. After release, state is IDLE; with 6 words left and EN=1, a fresh burst of 4 starts.
- Random DO_RDY (50%) over 100 bursts of BURST=64 -> DO_DAT sequence equals FIFO write order, and exactly one LAST per 64 accepted words.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Pulls fixed-length bursts out of a show-ahead FIFO once it holds THRESH words,
// presenting them on a VLD/RDY stream through a 2-entry skid buffer with LAST.
`timescale 1ns/1ps
module fifo_burst_reader #(
    parameter int DWID   = 32,
    parameter int AWID   = 10,
    parameter int BURST  = 64,
    parameter int THRESH = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EN,
    output logic            FF_RDENA,
    input  logic [DWID-1:0] FF_RDDAT,
    input  logic [AWID-1:0] FF_RDLEV,
    output logic            DO_VLD,
    output logic [DWID-1:0] DO_DAT,
    output logic            DO_LAST,
    input  logic            DO_RDY,
    output logic            BUSY,
    output logic            UNDERRUN
);
    localparam int                RW       = $clog2(BURST + 1);
    localparam logic [RW-1:0]     BURST_L  = RW'(BURST);
    localparam logic [RW-1:0]     REM_ONE  = RW'(1);
    localparam logic [AWID-1:0]   THRESH_L = AWID'(THRESH);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   rem;
    logic [1:0]      occ;
    logic [DWID:0]   skid_head;
    logic [DWID:0]   skid_tail;
    logic            start;
    logic            pop;
    logic            accept;
    logic            starved;
    logic            last_in;

    assign start   = EN && (FF_RDLEV >= THRESH_L);
    assign pop     = FF_RDENA;
    assign accept  = DO_VLD && DO_RDY;
    assign last_in = (rem == REM_ONE);
    assign starved = (state == S_BURST) && (rem != '0) && (occ != 2'd2) && (FF_RDLEV == '0);

    assign DO_VLD  = (occ != 2'd0);
    assign DO_DAT  = skid_head[DWID-1:0];
    assign DO_LAST = skid_head[DWID];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BURST;
            S_BURST: if (pop && last_in) state_nxt = S_DRAIN;
            S_DRAIN: if (occ == 2'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        FF_RDENA = 1'b0;
        BUSY     = (state != S_IDLE);
        if (state == S_BURST) begin
            FF_RDENA = (FF_RDLEV != '0) && (occ != 2'd2) && (rem != '0);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rem      <= '0;
            UNDERRUN <= 1'b0;
        end else begin
            UNDERRUN <= starved;
            if (state == S_IDLE && start) begin
                rem <= BURST_L;
            end else if (pop) begin
                rem <= rem - REM_ONE;
            end
        end
    end

    // A pop lands in the head slot when the head is empty or leaving this cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            occ       <= 2'd0;
            skid_head <= '0;
            skid_tail <= '0;
        end else begin
            occ <= occ + {1'b0, pop} - {1'b0, accept};
            if (pop) begin
                if (occ == 2'd0 || (occ == 2'd1 && accept)) begin
                    skid_head <= {last_in, FF_RDDAT};
                end else begin
                    skid_tail <= {last_in, FF_RDDAT};
                end
            end else if (accept && occ == 2'd2) begin
                skid_head <= skid_tail;
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FIFO models feed three instances
// (BURST/THRESH 4/4, 4/1, 64/64); accepted words are scored against write order.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
    localparam int DW = 32;
    localparam int AW = 10;

    int n_tests = 0;
    int n_fail  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          en_a = 1'b0, rdy_a = 1'b0, rdena_a, vld_a, last_a, busy_a, und_a;
    logic [DW-1:0] rddat_a = '0, do_dat_a;
    logic [AW-1:0] rdlev_a = '0;
    logic          en_b = 1'b0, rdy_b = 1'b0, rdena_b, vld_b, last_b, busy_b, und_b;
    logic [DW-1:0] rddat_b = '0, do_dat_b;
    logic [AW-1:0] rdlev_b = '0;
    logic          en_c = 1'b0, rdy_c = 1'b0, rdena_c, vld_c, last_c, busy_c, und_c;
    logic [DW-1:0] rddat_c = '0, do_dat_c;
    logic [AW-1:0] rdlev_c = '0;

    fifo_burst_reader #(.DWID(DW), .AWID(AW), .BURST(4), .THRESH(4)) u_a (
        .CLK(clk), .RST(rst_n), .EN(en_a), .FF_RDENA(rdena_a), .FF_RDDAT(rddat_a),
        .FF_RDLEV(rdlev_a), .DO_VLD(vld_a), .DO_DAT(do_dat_a), .DO_LAST(last_a),
        .DO_RDY(rdy_a), .BUSY(busy_a), .UNDERRUN(und_a));
    fifo_burst_reader #(.DWID(DW), .AWID(AW), .BURST(4), .THRESH(1)) u_b (
        .CLK(clk), .RST(rst_n), .EN(en_b), .FF_RDENA(rdena_b), .FF_RDDAT(rddat_b),
        .FF_RDLEV(rdlev_b), .DO_VLD(vld_b), .DO_DAT(do_dat_b), .DO_LAST(last_b),
        .DO_RDY(rdy_b), .BUSY(busy_b), .UNDERRUN(und_b));
    fifo_burst_reader #(.DWID(DW), .AWID(AW), .BURST(64), .THRESH(64)) u_c (
        .CLK(clk), .RST(rst_n), .EN(en_c), .FF_RDENA(rdena_c), .FF_RDDAT(rddat_c),
        .FF_RDLEV(rdlev_c), .DO_VLD(vld_c), .DO_DAT(do_dat_c), .DO_LAST(last_c),
        .DO_RDY(rdy_c), .BUSY(busy_c), .UNDERRUN(und_c));

    // FIFO contents, accepted {last,data} words, and pop strobes seen before each edge
    logic [DW-1:0] qa[$], qb[$], qc[$], exp_c[$];
    logic [DW:0]   acc_a[$], acc_b[$], acc_c[$];
    logic          pp_a = 1'b0, pp_b = 1'b0, pp_c = 1'b0;
    int            und_cnt_a = 0;

    task automatic refresh();
        rdlev_a = AW'(qa.size()); rddat_a = (qa.size() != 0) ? qa[0] : '0;
        rdlev_b = AW'(qb.size()); rddat_b = (qb.size() != 0) ? qb[0] : '0;
        rdlev_c = AW'(qc.size()); rddat_c = (qc.size() != 0) ? qc[0] : '0;
    endtask

    task automatic push(input int k, input logic [DW-1:0] d);
        if (k == 0) qa.push_back(d);
        else if (k == 1) qb.push_back(d);
        else qc.push_back(d);
        refresh();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        pp_a = rdena_a;
        pp_b = rdena_b;
        pp_c = rdena_c;
        if (rst_n && vld_a && rdy_a) acc_a.push_back({last_a, do_dat_a});
        if (rst_n && vld_b && rdy_b) acc_b.push_back({last_b, do_dat_b});
        if (rst_n && vld_c && rdy_c) acc_c.push_back({last_c, do_dat_c});
        if (und_a) und_cnt_a++;
    end

    always begin
        @(posedge clk);
        #1;
        if (pp_a && qa.size() != 0) void'(qa.pop_front());
        if (pp_b && qb.size() != 0) void'(qb.pop_front());
        if (pp_c && qc.size() != 0) void'(qc.pop_front());
        refresh();
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        tick(); tick();
        @(negedge clk);
        n_tests++; if (vld_a !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", vld_a); end
        n_tests++; if (do_dat_a !== '0) begin n_fail++; $display("FAIL reset_dat: got %h expected 0", do_dat_a); end
        n_tests++; if (last_a !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", last_a); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_tests++; if (rdena_a !== 1'b0) begin n_fail++; $display("FAIL reset_rdena: got %b expected 0", rdena_a); end
        n_tests++; if (und_a !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", und_a); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] rd_v = '0, vld_v = '0, busy_v = '0;
        acc_a.delete();
        for (int i = 0; i < 4; i++) push(0, DW'(32'h10 + i));
        en_a = 1'b1; rdy_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rd_v[i] = rdena_a; vld_v[i] = vld_a; busy_v[i] = busy_a;
            if (i >= 2 && i <= 5) begin
                n_tests++;
                if ({last_a, do_dat_a} !== {(i == 5), DW'(32'h10 + i - 2)}) begin
                    n_fail++; $display("FAIL basic_word%0d: got %b/%h expected %b/%h", i - 2, last_a, do_dat_a, (i == 5), 32'h10 + i - 2);
                end
            end
            tick();
        end
        n_tests++; if (rd_v !== 8'b0001_1110) begin n_fail++; $display("FAIL basic_rdena: got %b expected 00011110", rd_v); end
        n_tests++; if (vld_v !== 8'b0011_1100) begin n_fail++; $display("FAIL basic_vld: got %b expected 00111100", vld_v); end
        n_tests++; if (busy_v !== 8'b0111_1110) begin n_fail++; $display("FAIL basic_busy: got %b expected 01111110", busy_v); end
        n_tests++; if (acc_a.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", acc_a.size()); end
    endtask

    task automatic test_threshold();
        logic any_rd = 1'b0, any_busy = 1'b0;
        int first = -1, n = 0;
        logic ok = 1'b1;
        acc_a.delete();
        for (int i = 0; i < 3; i++) push(0, DW'(32'h20 + i));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); any_rd |= rdena_a; any_busy |= busy_a; tick();
        end
        n_tests++; if (any_rd !== 1'b0) begin n_fail++; $display("FAIL thresh_rdena: got %b expected 0", any_rd); end
        n_tests++; if (any_busy !== 1'b0) begin n_fail++; $display("FAIL thresh_busy: got %b expected 0", any_busy); end
        push(0, 32'h23);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); if (vld_a && first < 0) first = k; tick();
        end
        n_tests++; if (first != 2) begin n_fail++; $display("FAIL thresh_latency: got %0d expected 2", first); end
        while (busy_a && n < 50) begin tick(); n++; end
        n_tests++; if (n >= 50) begin n_fail++; $display("FAIL thresh_timeout: busy got 1 expected 0"); end
        if (acc_a.size() != 4) ok = 1'b0;
        for (int i = 0; i < acc_a.size() && i < 4; i++)
            if (acc_a[i] !== {(i == 3), DW'(32'h20 + i)}) ok = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL thresh_data: got %0d words, order/last ok=%b expected 4 words ok=1", acc_a.size(), ok); end
    endtask

    task automatic test_backpressure();
        int n = 0;
        logic ok = 1'b1;
        acc_a.delete();
        for (int i = 0; i < 4; i++) push(0, DW'(32'h30 + i));
        rdy_a = 1'b1;
        tick(); tick(); tick();
        rdy_a = 1'b0;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            n_tests++;
            if ({vld_a, do_dat_a} !== {1'b1, DW'(32'h31)}) begin
                n_fail++; $display("FAIL bp_hold%0d: got %b/%h expected 1/31", h, vld_a, do_dat_a);
            end
            if (h >= 1) begin
                n_tests++;
                if (rdena_a !== 1'b0) begin n_fail++; $display("FAIL bp_rdena%0d: got %b expected 0", h, rdena_a); end
            end
            tick();
        end
        rdy_a = 1'b1;
        while (busy_a && n < 50) begin tick(); n++; end
        n_tests++; if (n >= 50) begin n_fail++; $display("FAIL bp_timeout: busy got 1 expected 0"); end
        if (acc_a.size() != 4) ok = 1'b0;
        for (int i = 0; i < acc_a.size() && i < 4; i++)
            if (acc_a[i] !== {(i == 3), DW'(32'h30 + i)}) ok = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_data: got %0d words ok=%b expected 4 words ok=1", acc_a.size(), ok); end
    endtask

    task automatic test_underrun();
        int n = 0;
        logic ok = 1'b1;
        acc_b.delete();
        rdy_b = 1'b1;
        push(1, 32'h40);
        en_b = 1'b1;
        tick(); tick(); tick(); tick();
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            n_tests++;
            if ({und_b, rdena_b, busy_b} !== 3'b101) begin
                n_fail++; $display("FAIL underrun_pulse%0d: got und/rdena/busy=%b%b%b expected 101", h, und_b, rdena_b, busy_b);
            end
            tick();
        end
        for (int i = 1; i < 4; i++) push(1, DW'(32'h40 + i));
        while (busy_b && n < 50) begin tick(); n++; end
        n_tests++; if (n >= 50) begin n_fail++; $display("FAIL underrun_timeout: busy got 1 expected 0"); end
        if (acc_b.size() != 4) ok = 1'b0;
        for (int i = 0; i < acc_b.size() && i < 4; i++)
            if (acc_b[i] !== {(i == 3), DW'(32'h40 + i)}) ok = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL underrun_data: got %0d words ok=%b expected 4 words ok=1", acc_b.size(), ok); end
        @(negedge clk);
        n_tests++; if (und_b !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b expected 0", und_b); end
        en_b = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int n = 0;
        logic ok = 1'b1;
        rdy_a = 1'b0;
        for (int i = 0; i < 8; i++) push(0, DW'(32'h50 + i));
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({vld_a, last_a, busy_a, rdena_a, und_a} !== 5'b0 || do_dat_a !== '0) begin
            n_fail++; $display("FAIL areset_outputs: got vld/last/busy/rdena/und=%b%b%b%b%b dat=%h expected all 0",
                               vld_a, last_a, busy_a, rdena_a, und_a, do_dat_a);
        end
        tick(); tick();
        acc_a.delete();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL areset_idle: busy got %b expected 0", busy_a); end
        tick();
        rdy_a = 1'b1;
        tick();
        while (busy_a && n < 50) begin tick(); n++; end
        n_tests++; if (n >= 50) begin n_fail++; $display("FAIL areset_timeout: busy got 1 expected 0"); end
        if (acc_a.size() != 4) ok = 1'b0;
        for (int i = 0; i < acc_a.size() && i < 4; i++)
            if (acc_a[i] !== {(i == 3), DW'(32'h52 + i)}) ok = 1'b0;
        n_tests++; if (!ok) begin n_fail++; $display("FAIL areset_data: got %0d words ok=%b expected 4 words ok=1", acc_a.size(), ok); end
        n_tests++; if (qa.size() != 2) begin n_fail++; $display("FAIL areset_left: got %0d expected 2", qa.size()); end
        en_a = 1'b0;
        qa.delete();
        refresh();
        tick();
    endtask

    task automatic test_random();
        int cyc = 0, written = 0, n = 0, bad = -1, badlast = -1, nlast = 0;
        logic [DW-1:0] d;
        acc_c.delete(); exp_c.delete();
        en_c = 1'b1;
        while (acc_c.size() < 6400 && cyc < 40000) begin
            rdy_c = 1'($urandom_range(0, 1));
            if (written < 6400 && qc.size() < 1000 && $urandom_range(0, 3) != 0) begin
                d = $urandom;
                exp_c.push_back(d);
                push(2, d);
                written++;
            end
            tick();
            cyc++;
        end
        rdy_c = 1'b1;
        while (busy_c && n < 50) begin tick(); n++; end
        n_tests++; if (acc_c.size() != 6400) begin n_fail++; $display("FAIL rand_count: got %0d expected 6400", acc_c.size()); end
        for (int i = 0; i < acc_c.size(); i++) begin
            if (bad < 0 && (i >= exp_c.size() || acc_c[i][DW-1:0] !== exp_c[i])) bad = i;
            if (acc_c[i][DW]) nlast++;
            if (badlast < 0 && acc_c[i][DW] !== ((i % 64) == 63)) badlast = i;
        end
        n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL rand_order: first wrong word index %0d expected none", bad); end
        n_tests++; if (nlast != 100) begin n_fail++; $display("FAIL rand_last_count: got %0d expected 100", nlast); end
        n_tests++; if (badlast >= 0) begin n_fail++; $display("FAIL rand_last_pos: misplaced LAST at index %0d expected none", badlast); end
        n_tests++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL rand_idle: busy got %b expected 0", busy_c); end
        en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_backpressure();
        test_underrun();
        test_async_reset();
        test_random();
        n_tests++; if (und_cnt_a != 0) begin n_fail++; $display("FAIL no_underrun_thresh_eq_burst: got %0d expected 0", und_cnt_a); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
